// File: rtl/hiscore_pkg.sv
// Shared types and constants for the high-score engine.
package hiscore_pkg;

    typedef enum logic [2:0] {
        WAIT    = 3'd0,
        CHECK   = 3'd1,
        IDLE    = 3'd2,
        RESTORE = 3'd3,
        SAVE    = 3'd4
    } state_t;

    localparam int SETTLE_CLKS = 2;
    localparam int CHECK_POLLS = 2;

endpackage

// File: rtl/hiscore_if.sv
// High-score port between the engine (master) and the game core (slave).
interface hiscore_if;
    logic        pause_req;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        hs_write;

    modport master (output pause_req, hs_address, hs_data_in, hs_write, input hs_data_out);
    modport slave  (input pause_req, hs_address, hs_data_in, hs_write, output hs_data_out);
endinterface

// File: rtl/hiscore_buf.sv
// 256x8 table buffer: one write port, two registered read ports (two RAM copies).
module hiscore_buf (
    input  logic       clk_49m,
    input  logic       reset_n,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [7:0] raddr_b,
    output logic [7:0] rdata_b
);
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;

    always_ff @(posedge clk_49m) begin
        if (we) begin
            mem_a[waddr] <= wdata;
            mem_b[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_a_d = mem_a[raddr_a];
        rd_b_d = mem_b[raddr_b];
    end

    always_ff @(posedge clk_49m) begin
        if (!reset_n) begin
            rd_a_q <= 8'h00;
            rd_b_q <= 8'h00;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign rdata_a = rd_a_q;
    assign rdata_b = rd_b_q;
endmodule

// File: rtl/hiscore_engine.sv
// High-score restore/save sequencer driving the core's high-score port.
// state   | meaning
// WAIT    | count startup vblanks
// CHECK   | poll first/last table byte for defaults each vblank
// IDLE    | table live, waiting for save
// RESTORE | core paused, buffer written into game RAM
// SAVE    | core paused, game RAM copied into buffer
module hiscore_engine
    import hiscore_pkg::*;
#(
    parameter logic [15:0] HS_BASE        = 16'h8800,
    parameter int          HS_LEN         = 64,
    parameter logic [7:0]  CHECK_START    = 8'h00,
    parameter logic [7:0]  CHECK_END      = 8'h00,
    parameter int          STARTUP_FRAMES = 120,
    parameter int          RD_LAT         = 2,
    parameter logic [7:0]  HS_INDEX       = 8'd4
) (
    input  logic        clk_49m,
    input  logic        reset_n,
    input  logic        video_vblank,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic [7:0]  ioctl_din,
    input  logic        save_req,
    hiscore_if.master   hs,
    output logic        busy,
    output logic        restored
);
    localparam logic [15:0] HS_END   = HS_BASE + 16'(HS_LEN - 1);
    localparam logic [7:0]  LAST_IDX = 8'(HS_LEN - 1);

    state_t      state_q, state_d;
    logic        vblank_q, dl_q;
    logic [15:0] frame_q, frame_d;
    logic [1:0]  sub_q, sub_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [7:0]  idx_q, idx_d;
    logic [1:0]  match_q, match_d;
    logic        start_ok_q, start_ok_d;
    logic [7:0]  sample_q, sample_d;
    logic        loaded_q, loaded_d;
    logic        pend_q, pend_d;
    logic        restored_q, restored_d;

    logic        vblank_rise, ioctl_hit, eng_we;
    logic [7:0]  eng_raddr, eng_rdata;

    assign vblank_rise = video_vblank & ~vblank_q;
    assign ioctl_hit   = ioctl_wr && (ioctl_index == HS_INDEX) && (ioctl_addr < 25'(HS_LEN));

    // Table must fit both the buffer and the 16-bit address space without wrapping.
    always_ff @(posedge clk_49m) begin
        assert (HS_LEN >= 1 && HS_LEN <= 256 && (32'(HS_BASE) + HS_LEN) <= 32'h1_0000
                && RD_LAT >= 1 && RD_LAT <= 255 && STARTUP_FRAMES >= 1);
    end

    hiscore_buf u_buf (
        .clk_49m (clk_49m),
        .reset_n (reset_n),
        .we      (ioctl_hit | eng_we),
        .waddr   (ioctl_hit ? ioctl_addr[7:0] : idx_q),
        .wdata   (ioctl_hit ? ioctl_data : sample_q),
        .raddr_a (eng_raddr),
        .rdata_a (eng_rdata),
        .raddr_b (ioctl_addr[7:0]),
        .rdata_b (ioctl_din)
    );

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        sub_d         = sub_q;
        tmr_d         = tmr_q;
        idx_d         = idx_q;
        match_d       = match_q;
        start_ok_d    = start_ok_q;
        sample_d      = sample_q;
        loaded_d      = loaded_q;
        pend_d        = pend_q;
        restored_d    = restored_q;
        eng_we        = 1'b0;
        eng_raddr     = idx_q;
        hs.pause_req  = 1'b0;
        hs.hs_address = 16'h0000;
        hs.hs_data_in = 8'h00;
        hs.hs_write   = 1'b0;

        if (save_req && state_q != IDLE) pend_d = 1'b1;

        case (state_q)
            WAIT: begin
                if (vblank_rise) begin
                    if (frame_q == 16'(STARTUP_FRAMES - 1)) begin
                        frame_d = 16'h0000;
                        state_d = CHECK;
                        sub_d   = 2'd1;
                        tmr_d   = 8'(RD_LAT - 1);
                        match_d = 2'd0;
                    end else begin
                        frame_d = frame_q + 16'd1;
                    end
                end
            end
            // sub 0: wait for vblank, 1: read first byte, 2: read last byte
            CHECK: begin
                case (sub_q)
                    2'd0: begin
                        if (vblank_rise) begin
                            sub_d = 2'd1;
                            tmr_d = 8'(RD_LAT - 1);
                        end
                    end
                    2'd1: begin
                        hs.hs_address = HS_BASE;
                        if (tmr_q == 8'd0) begin
                            start_ok_d = (hs.hs_data_out == CHECK_START);
                            sub_d      = 2'd2;
                            tmr_d      = 8'(RD_LAT - 1);
                        end else begin
                            tmr_d = tmr_q - 8'd1;
                        end
                    end
                    default: begin
                        hs.hs_address = HS_END;
                        if (tmr_q == 8'd0) begin
                            sub_d = 2'd0;
                            if (start_ok_q && hs.hs_data_out == CHECK_END) begin
                                if (match_q == 2'(CHECK_POLLS - 1)) begin
                                    match_d = 2'd0;
                                    idx_d   = 8'd0;
                                    tmr_d   = 8'(SETTLE_CLKS - 1);
                                    state_d = loaded_q ? RESTORE : IDLE;
                                end else begin
                                    match_d = match_q + 2'd1;
                                end
                            end else begin
                                match_d = 2'd0;
                            end
                        end else begin
                            tmr_d = tmr_q - 8'd1;
                        end
                    end
                endcase
            end
            // Buffer is read one byte ahead so each write cycle has its data ready.
            RESTORE: begin
                hs.pause_req = 1'b1;
                if (sub_q == 2'd0) begin
                    if (tmr_q == 8'd0) sub_d = 2'd1;
                    else tmr_d = tmr_q - 8'd1;
                end else begin
                    hs.hs_write   = 1'b1;
                    hs.hs_address = HS_BASE + {8'h00, idx_q};
                    hs.hs_data_in = eng_rdata;
                    eng_raddr     = idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        sub_d      = 2'd0;
                        restored_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            IDLE: begin
                if (pend_q || save_req) begin
                    state_d = SAVE;
                    pend_d  = 1'b0;
                    sub_d   = 2'd0;
                    tmr_d   = 8'(SETTLE_CLKS - 1);
                    idx_d   = 8'd0;
                end
            end
            // Per byte: RD_LAT address clocks (sample on the last), then one buffer write.
            SAVE: begin
                hs.pause_req = 1'b1;
                if (sub_q == 2'd0) begin
                    if (tmr_q == 8'd0) begin
                        sub_d = 2'd1;
                        tmr_d = 8'(RD_LAT);
                    end else begin
                        tmr_d = tmr_q - 8'd1;
                    end
                end else begin
                    hs.hs_address = HS_BASE + {8'h00, idx_q};
                    if (tmr_q == 8'd1) sample_d = hs.hs_data_out;
                    if (tmr_q == 8'd0) begin
                        eng_we = 1'b1;
                        tmr_d  = 8'(RD_LAT);
                        if (idx_q == LAST_IDX) begin
                            state_d  = IDLE;
                            sub_d    = 2'd0;
                            loaded_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end else begin
                        tmr_d = tmr_q - 8'd1;
                    end
                end
            end
            default: state_d = WAIT;
        endcase

        if (ioctl_download) begin
            state_d = WAIT;
            frame_d = 16'h0000;
            sub_d   = 2'd0;
        end
        if (ioctl_download && !dl_q && ioctl_index == HS_INDEX) loaded_d = 1'b0;
        if (ioctl_hit) loaded_d = 1'b1;
    end

    always_ff @(posedge clk_49m) begin
        if (!reset_n) begin
            state_q    <= WAIT;
            vblank_q   <= 1'b0;
            dl_q       <= 1'b0;
            frame_q    <= 16'h0000;
            sub_q      <= 2'd0;
            tmr_q      <= 8'd0;
            idx_q      <= 8'd0;
            match_q    <= 2'd0;
            start_ok_q <= 1'b0;
            sample_q   <= 8'h00;
            loaded_q   <= 1'b0;
            pend_q     <= 1'b0;
            restored_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vblank_q   <= video_vblank;
            dl_q       <= ioctl_download;
            frame_q    <= frame_d;
            sub_q      <= sub_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            match_q    <= match_d;
            start_ok_q <= start_ok_d;
            sample_q   <= sample_d;
            loaded_q   <= loaded_d;
            pend_q     <= pend_d;
            restored_q <= restored_d;
        end
    end

    assign busy     = (state_q == CHECK) || (state_q == RESTORE) || (state_q == SAVE);
    assign restored = restored_q;
endmodule

// File: tb/tb_hiscore_engine.sv
// Directed/randomized bench for hiscore_engine with a behavioural game-RAM core model.
module tb_hiscore_engine;
    import hiscore_pkg::*;

    localparam logic [15:0] HS_BASE  = 16'h8800;
    localparam int          HS_LEN   = 64;
    localparam logic [15:0] HS_END   = 16'h883F;
    localparam int          SAVE_CLK = 2 + 64 * 3;
    localparam int          REST_CLK = 2 + 64;

    logic        clk_49m = 1'b0;
    logic        reset_n;
    logic        video_vblank = 1'b0;
    logic        ioctl_download, ioctl_wr, save_req;
    logic [7:0]  ioctl_index, ioctl_data, ioctl_din;
    logic [24:0] ioctl_addr;
    logic        busy, restored;

    hiscore_if hs ();

    hiscore_engine #(
        .HS_BASE(16'h8800), .HS_LEN(64), .CHECK_START(8'h00), .CHECK_END(8'h00),
        .STARTUP_FRAMES(120), .RD_LAT(2), .HS_INDEX(8'd4)
    ) dut (
        .clk_49m(clk_49m), .reset_n(reset_n), .video_vblank(video_vblank),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_din(ioctl_din),
        .save_req(save_req), .hs(hs), .busy(busy), .restored(restored)
    );

    always #5 clk_49m = ~clk_49m;

    int vb_cnt = 0;
    always @(posedge clk_49m) begin
        vb_cnt       <= (vb_cnt == 39) ? 0 : vb_cnt + 1;
        video_vblank <= (vb_cnt < 4);
    end

    // Game core: registered read, write strobe, plus bench back-door poke/fill.
    logic [7:0]  game_ram [0:65535];
    logic [7:0]  fill_pat [HS_LEN];
    logic        poke_en = 1'b0, fill_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;
    logic [7:0]  poke_data = 8'h0;
    always @(posedge clk_49m) begin
        if (fill_en) for (int i = 0; i < HS_LEN; i++) game_ram[HS_BASE + 16'(i)] <= fill_pat[i];
        if (poke_en) game_ram[poke_addr] <= poke_data;
        if (hs.hs_write) game_ram[hs.hs_address] <= hs.hs_data_in;
        hs.hs_data_out <= game_ram[hs.hs_address];
    end

    int   write_cnt = 0, end_reads = 0;
    logic end_prev = 1'b0;
    always @(posedge clk_49m) begin
        if (hs.hs_write) write_cnt <= write_cnt + 1;
        end_prev <= (hs.hs_address == HS_END) && !hs.pause_req;
        if ((hs.hs_address == HS_END) && !hs.pause_req && !end_prev) end_reads <= end_reads + 1;
    end

    int checks = 0, errors = 0;
    logic [7:0] exp_buf [HS_LEN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_49m);
        #1;
    endtask

    task automatic wait_pause(input logic level, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (hs.pause_req === level) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_busy(input logic level, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (busy === level) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic measure_pause(output int len);
        len = 0;
        while (hs.pause_req === 1'b1 && len < 1000) begin len++; tick(); end
    endtask

    task automatic ioctl_write(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic read_buf(input logic [7:0] a, output logic [7:0] d);
        ioctl_addr = {17'h0, a};
        tick();
        d = ioctl_din;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic fill_go();
        fill_en = 1'b1;
        tick();
        fill_en = 1'b0;
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
    endtask

    task automatic check_buffer(input string tag);
        logic [7:0] d;
        for (int i = 0; i < HS_LEN; i++) begin
            read_buf(8'(i), d);
            check(tag, d, exp_buf[i]);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < HS_LEN; i++) check(tag, game_ram[HS_BASE + 16'(i)], exp_buf[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int len, w0, e0;
        logic [7:0] d;

        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; save_req = 1'b0;
        ioctl_index = 8'd0; ioctl_data = 8'd0; ioctl_addr = 25'd0;
        for (int i = 0; i < HS_LEN; i++) fill_pat[i] = 8'h00;
        fill_go();
        tick(); tick();
        check("rst_pause", hs.pause_req, 0);
        check("rst_addr", hs.hs_address, 0);
        check("rst_wdata", hs.hs_data_in, 0);
        check("rst_write", hs.hs_write, 0);
        check("rst_busy", busy, 0);
        check("rst_restored", restored, 0);
        check("rst_din", ioctl_din, 0);
        check("rst_state", 32'(dut.state_q), 32'(WAIT));
        reset_n = 1'b1;

        // No table loaded, defaults match: engine goes idle without writing.
        w0 = write_cnt;
        wait_busy(1'b1, 6000, ok);
        check("noload_check_entry", ok, 1);
        wait_busy(1'b0, 300, ok);
        check("noload_idle_reached", ok, 1);
        check("noload_state", 32'(dut.state_q), 32'(IDLE));
        check("noload_no_writes", write_cnt - w0, 0);
        check("noload_restored", restored, 0);

        // Save from IDLE.
        for (int i = 0; i < HS_LEN; i++) begin fill_pat[i] = 8'hA0 + 8'(i); exp_buf[i] = 8'hA0 + 8'(i); end
        fill_go();
        w0 = write_cnt;
        pulse_save();
        measure_pause(len);
        check("save_pause_len", len, SAVE_CLK);
        check("save_no_writes", write_cnt - w0, 0);
        read_buf(8'd5, d);
        check("save_byte5", d, 8'hA5);
        check_buffer("save_buf");
        check("save_busy_done", busy, 0);

        // Load 0x00..0x3F, last RAM byte wrong until fixed mid-CHECK.
        ioctl_index = 8'd4; ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < HS_LEN; i++) begin ioctl_write(25'(i), 8'(i)); exp_buf[i] = 8'(i); end
        ioctl_write(25'd64, 8'hEE);
        ioctl_write(25'd261, 8'h77);
        for (int i = 0; i < HS_LEN; i++) fill_pat[i] = 8'h00;
        fill_pat[HS_LEN-1] = 8'h55;
        fill_go();
        ioctl_download = 1'b0;
        w0 = write_cnt;
        wait_busy(1'b1, 6000, ok);
        check("mm_check_entry", ok, 1);
        e0 = end_reads;
        for (int i = 0; i < 120; i++) tick();
        check("mm_repolls", (end_reads - e0) >= 2, 1);
        check("mm_state", 32'(dut.state_q), 32'(CHECK));
        check("mm_no_writes", write_cnt - w0, 0);
        check("mm_restored", restored, 0);
        for (int i = 0; i < 45 && video_vblank !== 1'b1; i++) tick();
        for (int i = 0; i < 20; i++) tick();
        poke(HS_END, 8'h00);
        e0 = end_reads;
        wait_pause(1'b1, 300, ok);
        check("fix_restore_start", ok, 1);
        check("fix_polls", end_reads - e0, 2);
        measure_pause(len);
        check("restore_pause_len", len, REST_CLK);
        check("restore_writes", write_cnt - w0, HS_LEN);
        check_ram("restore_ram");
        check("restore_flag", restored, 1);
        read_buf(8'd5, d);
        check("oob_write_ignored", d, 8'h05);

        // Random table; save requested in the middle of the restore.
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < HS_LEN; i++) begin
            exp_buf[i] = 8'($urandom_range(0, 255));
            ioctl_write(25'(i), exp_buf[i]);
        end
        for (int i = 0; i < HS_LEN; i++) fill_pat[i] = 8'h00;
        fill_go();
        ioctl_download = 1'b0;
        wait_pause(1'b1, 6000, ok);
        check("rnd_restore_start", ok, 1);
        for (int i = 0; i < 20; i++) tick();
        pulse_save();
        measure_pause(len);
        check("rnd_restore_len", len + 21, REST_CLK);
        check("idle_gap_pause", hs.pause_req, 0);
        check("idle_gap_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        check("pend_save_start", hs.pause_req, 1);
        measure_pause(len);
        check("pend_save_len", len, SAVE_CLK);
        check_ram("rnd_restore_ram");
        check_buffer("pend_save_buf");

        // Random RAM contents saved from IDLE.
        for (int i = 0; i < HS_LEN; i++) begin
            fill_pat[i] = 8'($urandom_range(0, 255));
            exp_buf[i] = fill_pat[i];
        end
        fill_go();
        pulse_save();
        measure_pause(len);
        check("rnd_save_len", len, SAVE_CLK);
        check_buffer("rnd_save_buf");

        // Reset in the middle of a save.
        pulse_save();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (hs.hs_address === HS_BASE + 16'd10) begin ok = 1'b1; break; end
            tick();
        end
        check("midsave_byte10_seen", ok, 1);
        reset_n = 1'b0;
        tick();
        check("midsave_rst_pause", hs.pause_req, 0);
        check("midsave_rst_write", hs.hs_write, 0);
        check("midsave_rst_busy", busy, 0);
        check("midsave_rst_state", 32'(dut.state_q), 32'(WAIT));
        check("midsave_rst_restored", restored, 0);
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
